// File: rtl/mazesolver_ram_arb_pkg.sv
// Shared types and default widths for the maze-solver RAM arbiter.
package mazesolver_ram_arb_pkg;

    localparam int ARB_ADDR_W   = 10;
    localparam int ARB_DATA_W   = 32;
    localparam int ARB_BE_W     = ARB_DATA_W / 8;
    localparam int ARB_LOCK_MAX = 16;

    typedef enum logic {ARB = 1'b0, HOLD = 1'b1} arb_state_t;
    typedef enum logic {M0 = 1'b0, M1 = 1'b1} owner_t;

    // The requester that is not o.
    function automatic owner_t other(input owner_t o);
        return (o == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/mazesolver_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, contention goes to ptr.
module mazesolver_rr_pick2
    import mazesolver_ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // One-hot grant, or none when nobody asks
    always_comb begin
        gnt = req;
        if (req[0] && req[1]) gnt = ptr ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/mazesolver_ram_arbiter.sv
// Arbiter sharing the single-port on-chip RAM between the Nios data master (m0)
// and the maze walker (m1). One access per cycle, read data one cycle later.
// Build option: MAZE_RAM_ARB_FIXED_PRI_EN makes m1 win contention, except for the
// single cycle after a lock timeout where the non-owner gets priority.
module mazesolver_ram_arbiter
    import mazesolver_ram_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int BE_W     = ARB_BE_W,
    parameter int LOCK_MAX = ARB_LOCK_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int               CNT_W   = $clog2(LOCK_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_MAX - 1);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d, cnt_inc;
    logic [1:0]        rdv_q;
    logic [ADDR_W-1:0] last_addr_q;

    logic [1:0] req, gnt, pick_gnt;
    logic       pick_ptr, gnt_any, gnt_read, gnt_lock, own_lock, timeout;
    owner_t     gnt_id;

    assign req      = {m1_read | m1_write, m0_read | m0_write};
    assign cnt_inc  = lock_cnt_q + CNT_ONE;
    assign timeout  = (cnt_inc >= CNT_LIM);
    assign own_lock = (owner_q == M1) ? m1_lock : m0_lock;

`ifdef MAZE_RAM_ARB_FIXED_PRI_EN
    logic pri_ovr_q, pri_ovr_d;

    // Walker wins contention unless the previous owner just timed out
    assign pick_ptr = pri_ovr_q ? rr_ptr_q : M1;
    assign pri_ovr_d = (state_q == HOLD) && timeout;

    // One-shot priority flag for the non-owner after a lock timeout
    always_ff @(posedge clk) begin
        if (reset) pri_ovr_q <= 1'b0;
        else       pri_ovr_q <= pri_ovr_d;
    end
`else
    assign pick_ptr = rr_ptr_q;
`endif

    mazesolver_rr_pick2 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .gnt (pick_gnt)
    );

    // Grant: nobody in reset, only the owner while locked, else the picker
    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            if (state_q == HOLD) gnt = (owner_q == M1) ? {req[1], 1'b0} : {1'b0, req[0]};
            else                 gnt = pick_gnt;
        end
    end

    assign gnt_any = |gnt;
    assign gnt_id  = gnt[1] ? M1 : M0;

    // Route the granted master onto the RAM port; idle cycles keep the last address
    always_comb begin
        mem_address    = last_addr_q;
        mem_byteenable = {BE_W{1'b1}};
        mem_writedata  = m0_writedata;
        mem_write      = 1'b0;
        gnt_read       = 1'b0;
        gnt_lock       = 1'b0;
        if (gnt[1]) begin
            mem_address   = m1_address;
            mem_writedata = m1_writedata;
            mem_write     = m1_write;
            gnt_read      = m1_read & ~m1_write;
            gnt_lock      = m1_lock;
            if (m1_write) mem_byteenable = m1_byteenable;
        end else if (gnt[0]) begin
            mem_address   = m0_address;
            mem_writedata = m0_writedata;
            mem_write     = m0_write;
            gnt_read      = m0_read & ~m0_write;
            gnt_lock      = m0_lock;
            if (m0_write) mem_byteenable = m0_byteenable;
        end
    end

    assign mem_chipselect   = gnt_any;
    assign mem_clken        = 1'b1;
    assign m0_waitrequest   = ~gnt[0];
    assign m1_waitrequest   = ~gnt[1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    // Gating with reset drops a response that was in flight when reset hit
    assign m0_readdatavalid = rdv_q[0] & ~reset;
    assign m1_readdatavalid = rdv_q[1] & ~reset;

    // Next state: lock acquisition, hold counting, release and pointer rotation
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        if (gnt_any) rr_ptr_d = other(gnt_id);
        if (state_q == ARB) begin
            if (gnt_any && gnt_lock) begin
                state_d    = HOLD;
                owner_d    = gnt_id;
                lock_cnt_d = CNT_ONE;
            end
        end else begin
            lock_cnt_d = cnt_inc;
            if (!own_lock || timeout) begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
            // A timed-out owner hands the next contention to the other side
            if (timeout) rr_ptr_d = other(owner_q);
        end
    end

    // State, read-response tags and the held address
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB;
            owner_q     <= M0;
            rr_ptr_q    <= M0;
            lock_cnt_q  <= '0;
            rdv_q       <= 2'b00;
            last_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            rdv_q      <= {gnt[1] & gnt_read, gnt[0] & gnt_read};
            if (gnt_any) last_addr_q <= mem_address;
        end
    end

endmodule

// File: tb/tb_mazesolver_ram_arbiter.sv
// Bench for mazesolver_ram_arbiter: directed table, lock/reset sequences and a
// randomized run against a cycle-level reference of the arbitration rules.
module tb_mazesolver_ram_arbiter;

    localparam int LOCK_MAX = 16;
`ifdef MAZE_RAM_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
    logic [9:0]  m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken;

    always #5 clk = ~clk;

    mazesolver_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_lock(m0_lock),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_read(m1_read), .m1_write(m1_write), .m1_lock(m1_lock),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // RAM: registered-address read, byte-lane writes
    logic [31:0] ram [0:1023];
    logic [31:0] ram_q;
    assign mem_readdata = ram_q;
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    // Reference state
    logic [31:0] ref_mem [0:1023];
    bit          r_locked, r_boost;
    int          r_owner, r_held, r_fav;
    bit   [1:0]  r_pend;
    logic [31:0] r_pend_data;
    int          checks = 0, errors = 0;
    logic        s_wait0, s_wait1, s_rdv0, s_rdv1;
    logic [31:0] s_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Who gets the port this cycle (-1 = nobody)
    function automatic int ref_grant(input bit q0, input bit q1);
        if (reset) return -1;
        if (r_locked) return ((r_owner == 0 && q0) || (r_owner == 1 && q1)) ? r_owner : -1;
        if (q0 && q1) return FIXED ? (r_boost ? r_fav : 1) : r_fav;
        if (q0) return 0;
        if (q1) return 1;
        return -1;
    endfunction

    task automatic idle();
        m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
        m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
    endtask

    // One clock: compare outputs mid-cycle against the reference, then advance it
    task automatic step();
        bit q0, q1, ev0, ev1, olock;
        int g;
        @(negedge clk);
        q0 = m0_read | m0_write;
        q1 = m1_read | m1_write;
        g  = ref_grant(q0, q1);
        s_wait0 = m0_waitrequest; s_wait1 = m1_waitrequest;
        s_rdv0 = m0_readdatavalid; s_rdv1 = m1_readdatavalid; s_rdata = m0_readdata;
        chk("wait0", 32'(m0_waitrequest), 32'(g != 0));
        chk("wait1", 32'(m1_waitrequest), 32'(g != 1));
        chk("chipselect", 32'(mem_chipselect), 32'(g >= 0));
        chk("mem_write", 32'(mem_write), 32'(g == 0 ? m0_write : (g == 1 ? m1_write : 1'b0)));
        chk("clken", 32'(mem_clken), 32'd1);
        if (g >= 0) begin
            chk("mem_address", 32'(mem_address), 32'(g == 0 ? m0_address : m1_address));
            if (g == 0) chk("mem_be", 32'(mem_byteenable), 32'(m0_write ? m0_byteenable : 4'hF));
            else        chk("mem_be", 32'(mem_byteenable), 32'(m1_write ? m1_byteenable : 4'hF));
        end
        ev0 = r_pend[0] && !reset;
        ev1 = r_pend[1] && !reset;
        chk("rdv0", 32'(m0_readdatavalid), 32'(ev0));
        chk("rdv1", 32'(m1_readdatavalid), 32'(ev1));
        if (ev0) chk("rdata0", m0_readdata, r_pend_data);
        if (ev1) chk("rdata1", m1_readdata, r_pend_data);
        @(posedge clk);
        if (reset) begin
            r_locked = 0; r_boost = 0; r_fav = 0; r_held = 0; r_pend = 2'b00;
        end else begin
            r_pend = {bit'(g == 1 && m1_read), bit'(g == 0 && m0_read)};
            if (g == 0 && m0_read)  r_pend_data = ref_mem[m0_address];
            if (g == 1 && m1_read)  r_pend_data = ref_mem[m1_address];
            if (g == 0 && m0_write) ref_mem[m0_address] = merge(ref_mem[m0_address], m0_writedata, m0_byteenable);
            if (g == 1 && m1_write) ref_mem[m1_address] = merge(ref_mem[m1_address], m1_writedata, m1_byteenable);
            if (g >= 0) r_fav = 1 - g;
            r_boost = 0;
            if (r_locked) begin
                olock = (r_owner == 0) ? m0_lock : m1_lock;
                r_held++;
                if (r_held >= LOCK_MAX - 1) begin
                    r_locked = 0; r_fav = 1 - r_owner; r_boost = 1;
                end else if (!olock) begin
                    r_locked = 0;
                end
            end else if (g >= 0 && (g == 0 ? m0_lock : m1_lock)) begin
                r_locked = 1; r_owner = g; r_held = 1;
            end
        end
        #1;
    endtask

    typedef struct {
        int          op0;  logic [9:0] a0;
        int          op1;  logic [9:0] a1; logic [3:0] be1; logic [31:0] d1;
        logic        ew0, ew1, ev0, ev1;
        logic [31:0] edata;
    } vec_t;
    vec_t tbl [10];

    function automatic vec_t mk(input int op0, input logic [9:0] a0, input int op1, input logic [9:0] a1,
                                input logic [3:0] be1, input logic [31:0] d1, input logic ew0, input logic ew1,
                                input logic ev0, input logic ev1, input logic [31:0] edata);
        vec_t v;
        v.op0 = op0; v.a0 = a0; v.op1 = op1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.ew0 = ew0; v.ew1 = ew1; v.ev0 = ev0; v.ev1 = ev1; v.edata = edata;
        return v;
    endfunction

    initial begin
        int wait_n, st, b0, b1;
        bit got;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 32'hC0DE0000 | 32'(i);
            ref_mem[i] = ram[i];
        end
        ram[10'h005] = 32'hDEADBEEF; ref_mem[10'h005] = 32'hDEADBEEF;
        ram[10'h3FF] = 32'hFFFFFFFF; ref_mem[10'h3FF] = 32'hFFFFFFFF;
        ram_q = '0;
        r_locked = 0; r_boost = 0; r_fav = 0; r_held = 0; r_owner = 0; r_pend = 2'b00; r_pend_data = '0;

        // ops: 0 idle, 1 read, 2 write
        tbl[0] = mk(1, 10'h005, 0, 10'h000, 4'hF, 32'h0, 0, 1, 0, 0, 32'h0);
        tbl[1] = mk(0, 10'h000, 1, 10'h020, 4'hF, 32'h0, 1, 0, 1, 0, 32'hDEADBEEF);
        if (!FIXED) begin
            tbl[2] = mk(1, 10'h010, 1, 10'h020, 4'hF, 32'h0, 0, 1, 0, 1, 32'hC0DE0020);
            tbl[3] = mk(1, 10'h010, 1, 10'h020, 4'hF, 32'h0, 1, 0, 1, 0, 32'hC0DE0010);
            tbl[4] = mk(1, 10'h010, 1, 10'h020, 4'hF, 32'h0, 0, 1, 0, 1, 32'hC0DE0020);
            tbl[5] = mk(1, 10'h010, 1, 10'h020, 4'hF, 32'h0, 1, 0, 1, 0, 32'hC0DE0010);
        end else begin
            for (int i = 2; i < 6; i++)
                tbl[i] = mk(1, 10'h010, 1, 10'h020, 4'hF, 32'h0, 1, 0, 0, 1, 32'hC0DE0020);
        end
        tbl[6] = mk(0, 10'h000, 0, 10'h000, 4'hF, 32'h0, 1, 1, FIXED ? 1'b0 : 1'b0, 1, 32'hC0DE0020);
        tbl[7] = mk(0, 10'h000, 2, 10'h3FF, 4'b0011, 32'h12345678, 1, 0, 0, 0, 32'h0);
        tbl[8] = mk(0, 10'h000, 1, 10'h3FF, 4'hF, 32'h0, 1, 0, 0, 0, 32'h0);
        tbl[9] = mk(0, 10'h000, 0, 10'h000, 4'hF, 32'h0, 1, 1, 0, 1, 32'hFFFF5678);

        // Reset with both masters asking
        idle(); reset = 1; m0_read = 1; m1_read = 1;
        step(); step();
        chk("rst_wait0", 32'(s_wait0), 32'd1);
        chk("rst_wait1", 32'(s_wait1), 32'd1);
        chk("rst_rdv", 32'({s_rdv1, s_rdv0}), 32'd0);
        reset = 0; idle();
        step();

        foreach (tbl[i]) begin
            idle();
            m0_read = (tbl[i].op0 == 1); m0_write = (tbl[i].op0 == 2); m0_address = tbl[i].a0;
            m1_read = (tbl[i].op1 == 1); m1_write = (tbl[i].op1 == 2); m1_address = tbl[i].a1;
            m1_byteenable = tbl[i].be1; m1_writedata = tbl[i].d1;
            step();
            chk($sformatf("tbl%0d_wait0", i), 32'(s_wait0), 32'(tbl[i].ew0));
            chk($sformatf("tbl%0d_wait1", i), 32'(s_wait1), 32'(tbl[i].ew1));
            chk($sformatf("tbl%0d_rdv0", i), 32'(s_rdv0), 32'(tbl[i].ev0));
            chk($sformatf("tbl%0d_rdv1", i), 32'(s_rdv1), 32'(tbl[i].ev1));
            if (tbl[i].ev0 || tbl[i].ev1) chk($sformatf("tbl%0d_rdata", i), s_rdata, tbl[i].edata);
        end

        // m0 holds a lock for 20 cycles while m1 keeps asking; in the fixed build m1
        // joins one cycle late so m0 can take the lock first
        st = FIXED ? 1 : 0; wait_n = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            idle();
            m0_read = (c < 20); m0_lock = (c < 20); m0_address = 10'(10'h040 + c);
            m1_read = (c >= st); m1_address = 10'h050;
            step();
            if (c >= st) begin
                if (s_wait1) wait_n++;
                else begin
                    got = 1;
                    chk("lock_handoff_wait0", 32'(s_wait0), 32'd1);
                end
            end
        end
        chk("lock_m1_granted", 32'(got), 32'd1);
        chk("lock_m1_wait_cycles", 32'(wait_n), 32'(LOCK_MAX - 1 - st));
        idle(); step();

        // Reset right after an accepted m1 read
        idle(); m1_read = 1; m1_address = 10'h005; step();
        chk("pre_rst_accept", 32'(s_wait1), 32'd0);
        idle(); reset = 1; m0_read = 1; step();
        chk("rst_drop_rdv1", 32'(s_rdv1), 32'd0);
        chk("rst_block_m0", 32'(s_wait0), 32'd1);
        reset = 0; idle(); m0_read = 1; m0_address = 10'h011; step();
        chk("post_rst_rdv1", 32'(s_rdv1), 32'd0);
        idle(); reset = 1; step();
        reset = 0; m0_read = 1; m1_read = 1; m0_address = 10'h012; m1_address = 10'h013; step();
        chk("rst_ptr_wait0", 32'(s_wait0), 32'(FIXED));
        chk("rst_ptr_wait1", 32'(s_wait1), 32'(!FIXED));
        idle(); step();

        // Random traffic with lock bursts and occasional resets
        b0 = 0; b1 = 0;
        for (int c = 0; c < 3000; c++) begin
            int op0, op1;
            reset = ($urandom_range(0, 99) < 2);
            if (b0 == 0 && $urandom_range(0, 39) == 0) b0 = $urandom_range(5, 25);
            if (b1 == 0 && $urandom_range(0, 39) == 0) b1 = $urandom_range(5, 25);
            op0 = (b0 > 0) ? 1 + $urandom_range(0, 1) : $urandom_range(0, 3);
            op1 = (b1 > 0) ? 1 + $urandom_range(0, 1) : $urandom_range(0, 3);
            m0_read = (op0 == 1 || op0 == 3); m0_write = (op0 == 2);
            m1_read = (op1 == 1 || op1 == 3); m1_write = (op1 == 2);
            m0_lock = (b0 > 0) || ($urandom_range(0, 7) == 0);
            m1_lock = (b1 > 0) || ($urandom_range(0, 7) == 0);
            m0_address = 10'(10'h3F8 + $urandom_range(0, 7));
            m1_address = 10'(10'h3F8 + $urandom_range(0, 7));
            m0_byteenable = 4'($urandom_range(0, 15)); m1_byteenable = 4'($urandom_range(0, 15));
            m0_writedata = $urandom; m1_writedata = $urandom;
            if (b0 > 0) b0--;
            if (b1 > 0) b1--;
            step();
        end
        reset = 0; idle(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
